peripheral_wb_pattern_master: RTL and testbench

Synthesizable Wishbone B4 initiator that exercises a memory-mapped slave such as the single-port RAM. On `start_i` it writes a deterministic pattern over an address window using classic or linear incrementing bursts, then reads the window back and compares. It reports completion, mismatch count and first failing address. It is the on-chip counterpart of the bench-only Wishbone transactor, for self-test of SPRAM instances in silicon or FPGA.

---
 rtl/peripheral_wb_pkg.sv | 13 +
 rtl/peripheral_wb_pattern_checker.sv | 48 ++++
 rtl/peripheral_wb_pattern_master.sv | 188 ++++++++++++++++++
 tb/tb_peripheral_wb_pattern_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone constants, FSM state type and the self-test data pattern.
package peripheral_wb_pkg;
   localparam logic [2:0] CLASSIC = 3'b000;
   localparam logic [2:0] INCR    = 3'b010;
   localparam logic [2:0] EOB     = 3'b111;
   localparam logic [1:0] LINEAR  = 2'b00;

   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

   function automatic logic [31:0] pat(input logic [15:0] idx, input logic [31:0] seed);
      return {~idx, idx} ^ seed;
   endfunction
endpackage

// File: rtl/peripheral_wb_pattern_checker.sv
// Read-back comparator: saturating mismatch counter plus first failing address.
module peripheral_wb_pattern_checker
   import peripheral_wb_pkg::*;
#(
   parameter int          AW   = 32,
   parameter logic [31:0] SEED = 32'hA5A5_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          vld_i,
   input  logic [15:0]   idx_i,
   input  logic [AW-1:0] adr_i,
   input  logic [31:0]   dat_i,
   output logic [15:0]   err_cnt_o,
   output logic [AW-1:0] fail_adr_o
);
   logic [15:0]   cnt_q, cnt_d;
   logic [AW-1:0] adr_q, adr_d;
   logic          miss;

   // The counter saturates instead of wrapping, so cnt_q == 0 reliably means "no miss yet".
   always_comb begin
      cnt_d = cnt_q;
      adr_d = adr_q;
      miss  = vld_i && (dat_i != pat(idx_i, SEED));
      if (clr_i) begin
         cnt_d = '0;
         adr_d = '0;
      end else if (miss) begin
         if (cnt_q == 16'h0000) adr_d = adr_i;
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         adr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         adr_q <= adr_d;
      end
   end

   assign err_cnt_o  = cnt_q;
   assign fail_adr_o = adr_q;
endmodule

// File: rtl/peripheral_wb_pattern_master.sv
// Wishbone B4 self-test initiator: writes a pattern window in bursts, reads it back, reports mismatches.
module peripheral_wb_pattern_master
   import peripheral_wb_pkg::*;
#(
   parameter int          AW        = 32,
   parameter int          DW        = 32,
   parameter logic [AW-1:0] BASE_ADR = '0,
   parameter int          WORDS     = 1024,
   parameter int          BURST_LEN = 4,
   parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   output logic [AW-1:0] wb_adr_o,
   output logic [DW-1:0] wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          fail_o,
   output logic [15:0]   err_cnt_o,
   output logic [AW-1:0] fail_adr_o
);
   localparam logic [31:0] LAST_BEAT = 32'(BURST_LEN - 1);

   state_t        state_q, state_d;
   logic [31:0]   word_q, word_d, word_nx;
   logic [31:0]   beat_q, beat_d;
   logic          cyc_q, cyc_d, we_q, we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic [2:0]    cti_q, cti_d;
   logic          busy_q, busy_d, done_q, done_d, buserr_q, buserr_d;
   logic          clr, rd_vld, drop;

   function automatic logic [AW-1:0] adr_of(input logic [31:0] w);
      return BASE_ADR + AW'(w << 2);
   endfunction

   function automatic logic [2:0] cti_of(input logic [31:0] b);
      if (BURST_LEN == 1) return CLASSIC;
      return (b == LAST_BEAT) ? EOB : INCR;
   endfunction

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      beat_d   = beat_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      cti_d    = cti_q;
      busy_d   = busy_q;
      done_d   = done_q;
      buserr_d = buserr_q;
      clr      = 1'b0;
      rd_vld   = 1'b0;
      drop     = 1'b0;
      word_nx  = word_q + 32'd1;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d  = WR;
               clr      = 1'b1;
               buserr_d = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               word_d   = '0;
               beat_d   = '0;
               cyc_d    = 1'b1;
               we_d     = 1'b1;
               adr_d    = adr_of('0);
               dat_d    = pat(16'd0, SEED);
               cti_d    = cti_of('0);
            end
         end
         default: begin
            // A low cyc inside WR/RD is the one-cycle gap; the next burst resumes at word_q/beat_q.
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = (state_q == WR);
               adr_d = adr_of(word_q);
               dat_d = (state_q == WR) ? pat(word_q[15:0], SEED) : '0;
               cti_d = cti_of(beat_q);
            end else if (wb_err_i) begin
               drop     = 1'b1;
               state_d  = DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               buserr_d = 1'b1;
            end else if (wb_ack_i) begin
               rd_vld = (state_q == RD);
               if (word_nx == 32'(WORDS)) begin
                  drop   = 1'b1;
                  word_d = '0;
                  beat_d = '0;
                  if (state_q == WR) begin
                     state_d = RD;
                  end else begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else if (beat_q == LAST_BEAT) begin
                  drop   = 1'b1;
                  word_d = word_nx;
                  beat_d = '0;
               end else begin
                  word_d = word_nx;
                  beat_d = beat_q + 32'd1;
                  adr_d  = adr_of(word_nx);
                  dat_d  = (state_q == WR) ? pat(word_nx[15:0], SEED) : '0;
                  cti_d  = cti_of(beat_q + 32'd1);
               end
            end else if (wb_rty_i) begin
               drop = 1'b1;
            end
            if (drop) begin
               cyc_d = 1'b0;
               we_d  = 1'b0;
               cti_d = CLASSIC;
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         word_q   <= '0;
         beat_q   <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         cti_q    <= CLASSIC;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         buserr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         beat_q   <= beat_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         cti_q    <= cti_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         buserr_q <= buserr_d;
      end
   end

   peripheral_wb_pattern_checker #(.AW(AW), .SEED(SEED)) u_chk (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .clr_i      (clr),
      .vld_i      (rd_vld),
      .idx_i      (word_q[15:0]),
      .adr_i      (adr_q),
      .dat_i      (wb_dat_i),
      .err_cnt_o  (err_cnt_o),
      .fail_adr_o (fail_adr_o)
   );

   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = cyc_q ? 4'hF : 4'h0;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_cti_o = cti_q;
   assign wb_bte_o = LINEAR;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign fail_o   = (err_cnt_o != 16'h0000) | buserr_q;
endmodule

// File: tb/tb_peripheral_wb_pattern_master.sv
// Two pattern masters (4-beat bursts at 0x100, classic cycles at 0) against fault-injecting memory slaves.
module tb_peripheral_wb_pattern_master;
   localparam int          NI = 2;
   localparam int          WORDS_G [NI] = '{8, 16};
   localparam int          BL_G    [NI] = '{4, 1};
   localparam logic [31:0] BASE_G  [NI] = '{32'h100, 32'h0};

   logic clk = 1'b0;
   logic rst, start;
   always #5 clk = ~clk;

   logic [NI-1:0]       cyc, stb, we, ack, err, rty, busy, done, fail;
   logic [NI-1:0][31:0] adr, wdat, rdat, fadr;
   logic [NI-1:0][3:0]  sel;
   logic [NI-1:0][2:0]  cti;
   logic [NI-1:0][1:0]  bte;
   logic [NI-1:0][15:0] ecnt;

   int flip_w [NI], err_w [NI], rty_w [NI], waits [NI];
   int wr_acks [NI], rd_acks [NI], rd_cyc [NI], rty_cnt [NI], mism [NI];
   logic [31:0] first_bad [NI], rd3 [NI];
   logic [2:0]  cti_log [NI][8];
   logic [31:0] adr_log [NI][8];
   int total = 0, bad = 0;

   function automatic logic [31:0] bpat(input int i);
      logic [15:0] l;
      l = i[15:0];
      return {~l, l} ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int W  = WORDS_G[g];
      localparam int BL = BL_G[g];

      peripheral_wb_pattern_master #(
         .AW(32), .DW(32), .BASE_ADR(BASE_G[g]), .WORDS(W), .BURST_LEN(BL), .SEED(32'hA5A5_0000)
      ) dut (
         .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
         .wb_adr_o(adr[g]), .wb_dat_o(wdat[g]), .wb_sel_o(sel[g]), .wb_we_o(we[g]),
         .wb_cyc_o(cyc[g]), .wb_stb_o(stb[g]), .wb_cti_o(cti[g]), .wb_bte_o(bte[g]),
         .wb_dat_i(rdat[g]), .wb_ack_i(ack[g]), .wb_err_i(err[g]), .wb_rty_i(rty[g]),
         .busy_o(busy[g]), .done_o(done[g]), .fail_o(fail[g]),
         .err_cnt_o(ecnt[g]), .fail_adr_o(fadr[g])
      );

      // Memory slave: programmable wait states, one retry, an error beat and a read bit flip.
      logic [31:0] mem [16];
      logic [31:0] sidx;
      logic        resp, rty_used;
      int          wc;
      assign sidx    = (adr[g] - BASE_G[g]) >> 2;
      assign resp    = cyc[g] && stb[g] && (wc >= waits[g]);
      assign err[g]  = resp && we[g] && (int'(sidx) == err_w[g]);
      assign rty[g]  = resp && !err[g] && we[g] && (int'(sidx) == rty_w[g]) && !rty_used;
      assign ack[g]  = resp && !rty[g];
      assign rdat[g] = mem[sidx[3:0]] ^ ((!we[g] && int'(sidx) == flip_w[g]) ? 32'h1 : 32'h0);

      always @(posedge clk) begin
         if (rst || !(cyc[g] && stb[g]) || resp) wc <= 0;
         else wc <= wc + 1;
         if (start) rty_used <= 1'b0;
         else if (rty[g]) rty_used <= 1'b1;
         if (ack[g] && !err[g] && we[g]) mem[sidx[3:0]] <= wdat[g];
      end

      // Reference model: beat index xi walks the window; every bus beat is checked against it.
      int xi, gap;
      bit rdp, prev_cyc, must_drop, exp_done, exp_err, seen;
      always @(negedge clk) begin
         if (rst || (start && !busy[g])) begin
            xi = 0; gap = 0; rdp = 0; prev_cyc = 0; must_drop = 0;
            exp_done = 0; exp_err = 0; seen = 0;
            wr_acks[g] = 0; rd_acks[g] = 0; rd_cyc[g] = 0; rty_cnt[g] = 0; mism[g] = 0;
            first_bad[g] = 0; rd3[g] = 0;
         end else begin
            if (exp_done || exp_err) begin
               chk("done_rise", 32'(done[g]), 1);
               chk("busy_fall", 32'(busy[g]), 0);
               if (exp_err) chk("err_fail", 32'(fail[g]), 1);
               exp_done = 0;
               exp_err  = 0;
            end
            if (seen && prev_cyc) chk(must_drop ? "cyc_drop" : "cyc_hold", 32'(cyc[g]), must_drop ? 0 : 1);
            must_drop = 0;
            if (cyc[g]) begin
               if (seen && !prev_cyc) chk("gap_len", gap, 1);
               gap  = 0;
               seen = 1;
               chk("stb", 32'(stb[g]), 1);
               chk("busy_in_cyc", 32'(busy[g]), 1);
               chk("done_in_cyc", 32'(done[g]), 0);
               chk("adr", adr[g], BASE_G[g] + 32'(4 * xi));
               chk("we", 32'(we[g]), rdp ? 0 : 1);
               if (!rdp) chk("wdat", wdat[g], bpat(xi));
               chk("sel", 32'(sel[g]), 32'hF);
               chk("cti", 32'(cti[g]), (BL == 1) ? 0 : ((xi % BL == BL - 1) ? 7 : 2));
               chk("bte", 32'(bte[g]), 0);
               if (!we[g]) rd_cyc[g]++;
               if (ack[g] && !err[g]) begin
                  if (!rdp) begin
                     wr_acks[g]++;
                     if (xi < 8) begin
                        cti_log[g][xi] = cti[g];
                        adr_log[g][xi] = adr[g];
                     end
                  end else begin
                     rd_acks[g]++;
                     if (rdat[g] != bpat(xi)) begin
                        if (mism[g] == 0) first_bad[g] = adr[g];
                        mism[g]++;
                     end
                     if (xi == 3) rd3[g] = rdat[g];
                  end
                  xi++;
                  must_drop = (xi % BL == 0);
                  if (xi == W) begin
                     if (rdp) exp_done = 1;
                     else begin
                        rdp = 1;
                        xi  = 0;
                     end
                  end
               end else if (err[g]) begin
                  must_drop = 1;
                  exp_err   = 1;
               end else if (rty[g]) begin
                  must_drop = 1;
                  rty_cnt[g]++;
               end
            end else begin
               gap++;
            end
            prev_cyc = cyc[g];
         end
      end
   end

   task automatic check_idle(input string tag);
      for (int g = 0; g < NI; g++) begin
         chk({tag, "_adr"}, adr[g], 0);
         chk({tag, "_dat"}, wdat[g], 0);
         chk({tag, "_sel"}, 32'(sel[g]), 0);
         chk({tag, "_we"}, 32'(we[g]), 0);
         chk({tag, "_cyc"}, 32'(cyc[g]), 0);
         chk({tag, "_stb"}, 32'(stb[g]), 0);
         chk({tag, "_cti"}, 32'(cti[g]), 0);
         chk({tag, "_bte"}, 32'(bte[g]), 0);
         chk({tag, "_busy"}, 32'(busy[g]), 0);
         chk({tag, "_done"}, 32'(done[g]), 0);
         chk({tag, "_fail"}, 32'(fail[g]), 0);
         chk({tag, "_ecnt"}, 32'(ecnt[g]), 0);
         chk({tag, "_fadr"}, fadr[g], 0);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run(input string tag);
      int n;
      n = 0;
      pulse_start();
      while (!(done[0] && done[1]) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_finish"}, 32'(done[0] && done[1]), 1);
   endtask

   task automatic end_chk(input string tag, input int g, input bit f, input int wr, input int rd,
                          input int ec, input logic [31:0] fa);
      chk({tag, "_done"}, 32'(done[g]), 1);
      chk({tag, "_busy"}, 32'(busy[g]), 0);
      chk({tag, "_cyc"}, 32'(cyc[g]), 0);
      chk({tag, "_fail"}, 32'(fail[g]), 32'(f));
      chk({tag, "_wr_acks"}, wr_acks[g], wr);
      chk({tag, "_rd_acks"}, rd_acks[g], rd);
      chk({tag, "_ecnt"}, 32'(ecnt[g]), ec);
      chk({tag, "_ecnt_model"}, 32'(ecnt[g]), mism[g]);
      chk({tag, "_fadr"}, fadr[g], fa);
      chk({tag, "_fadr_model"}, fadr[g], first_bad[g]);
   endtask

   initial begin
      int n;
      rst   = 1'b1;
      start = 1'b0;
      for (int g = 0; g < NI; g++) begin
         flip_w[g] = -1; err_w[g] = -1; rty_w[g] = -1; waits[g] = 0;
      end
      repeat (3) @(posedge clk);
      #1 check_idle("reset");
      rst = 1'b0;

      run("clean");
      for (int g = 0; g < NI; g++) end_chk("clean", g, 0, WORDS_G[g], WORDS_G[g], 0, 0);
      chk("word3_read", rd3[1], 32'h5A59_0003);
      chk("burst_cti0", 32'(cti_log[0][0]), 32'h2);
      chk("burst_cti1", 32'(cti_log[0][1]), 32'h2);
      chk("burst_cti2", 32'(cti_log[0][2]), 32'h2);
      chk("burst_cti3", 32'(cti_log[0][3]), 32'h7);
      chk("burst2_adr", adr_log[0][4], 32'h110);
      chk("burst2_last_adr", adr_log[0][7], 32'h11C);

      flip_w[0] = 5; flip_w[1] = 5; waits[0] = 2; waits[1] = 1;
      run("flip");
      end_chk("flip0", 0, 1, 8, 8, 1, 32'h114);
      end_chk("flip1", 1, 1, 16, 16, 1, 32'h14);

      flip_w[0] = -1; flip_w[1] = -1; waits[0] = 0; waits[1] = 0;
      rty_w[0] = 2; rty_w[1] = 2;
      run("retry");
      for (int g = 0; g < NI; g++) begin
         end_chk("retry", g, 0, WORDS_G[g], WORDS_G[g], 0, 0);
         chk("retry_seen", rty_cnt[g], 1);
      end

      rty_w[0] = -1; rty_w[1] = -1; err_w[0] = 3; err_w[1] = 3;
      run("buserr");
      for (int g = 0; g < NI; g++) begin
         end_chk("buserr", g, 1, 3, 0, 0, 0);
         chk("buserr_no_reads", rd_cyc[g], 0);
      end

      err_w[0] = -1; err_w[1] = -1; waits[0] = 2; waits[1] = 2;
      pulse_start();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(stb[0] && !we[0]) && n < 1000);
      chk("reach_read", 32'(stb[0] && !we[0]), 1);
      #1 rst = 1'b1;
      @(posedge clk); #1 check_idle("midrst");
      @(posedge clk); #1 rst = 1'b0;
      run("after_rst");
      for (int g = 0; g < NI; g++) end_chk("after_rst", g, 0, WORDS_G[g], WORDS_G[g], 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
